// File: rtl/dmem_responder_pkg.sv
// Shared funct3 codes, FSM encoding and request payload for the data-memory responder.
package dmem_responder_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic              write;
        logic [2:0]        f3;
        logic [DATA_W-1:0] wdata;
    } req_fields_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store port between the core (master) and the data-memory responder (slave).
interface dmem_responder_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [2:0]        req_f3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_f3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_f3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_lane_fmt.sv
// Byte-lane steering: store byte enables/replicated data, load extraction/extension, error detect.
module dmem_lane_fmt
    import dmem_responder_pkg::*;
(
    input  logic        write,
    input  logic [2:0]  f3,
    input  logic [1:0]  ofs,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be_c,
    output logic [31:0] wdata_c,
    output logic [31:0] rdata_c,
    output logic        err_c
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        illegal;
    logic        misaligned;

    // Decode access size; errored accesses get no byte enables and zero data.
    always_comb begin
        byte_sel   = rword[{ofs, 3'b000} +: 8];
        half_sel   = ofs[1] ? rword[31:16] : rword[15:0];
        illegal    = 1'b0;
        misaligned = 1'b0;
        be_c       = 4'b0000;
        wdata_c    = wdata;
        rdata_c    = 32'h0;
        case (f3)
            F3_B: begin
                be_c    = 4'b0001 << ofs;
                wdata_c = {4{wdata[7:0]}};
                rdata_c = {{24{byte_sel[7]}}, byte_sel};
            end
            F3_H: begin
                misaligned = ofs[0];
                be_c       = ofs[1] ? 4'b1100 : 4'b0011;
                wdata_c    = {2{wdata[15:0]}};
                rdata_c    = {{16{half_sel[15]}}, half_sel};
            end
            F3_W: begin
                misaligned = (ofs != 2'b00);
                be_c       = 4'b1111;
                rdata_c    = rword;
            end
            F3_BU: begin
                illegal = write;
                rdata_c = {24'h0, byte_sel};
            end
            F3_HU: begin
                illegal    = write;
                misaligned = ofs[0];
                rdata_c    = {16'h0, half_sel};
            end
            default: illegal = 1'b1;
        endcase
        err_c = illegal | misaligned;
        if (err_c) begin
            be_c    = 4'b0000;
            rdata_c = 32'h0;
        end
        if (write) begin
            rdata_c = 32'h0;
        end
    end
endmodule

// File: rtl/dmem_responder.sv
// Handshaked data memory with programmable wait states for the RV32I load/store port.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input logic             clk,
    input logic             rst,
    dmem_responder_if.slave bus
);
    localparam int unsigned WIDX_W = ADDR_W - 2;
    localparam int unsigned WORDS  = 1 << WIDX_W;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    req_fields_t       lat_q, live, acc;
    logic [ADDR_W-1:0] lat_addr, acc_addr;
    logic [WIDX_W-1:0] widx;
    logic [31:0]       mem [WORDS];
    logic              accept, exec;
    logic [3:0]        be;
    logic [31:0]       wsh, rfmt, rword;
    logic              ferr;

    // With zero wait states the access executes on the accept edge, so use the live request then.
    always_comb begin
        live     = '{write: bus.req_write, f3: bus.req_f3, wdata: bus.req_wdata};
        acc      = (state == S_IDLE) ? live : lat_q;
        acc_addr = (state == S_IDLE) ? bus.req_addr : lat_addr;
        widx     = acc_addr[ADDR_W-1:2];
        rword    = mem[widx];
    end

    dmem_lane_fmt u_fmt (
        .write   (acc.write),
        .f3      (acc.f3),
        .ofs     (acc_addr[1:0]),
        .wdata   (acc.wdata),
        .rword   (rword),
        .be_c    (be),
        .wdata_c (wsh),
        .rdata_c (rfmt),
        .err_c   (ferr)
    );

    // Next-state, wait counter and control strobes.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    accept     = 1'b1;
                    cnt_next   = CNT_LOAD;
                    state_next = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    state_next = S_RESP;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        exec = (state_next == S_RESP) && (state != S_RESP);
    end

    // State and wait counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Request capture on accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_q    <= '0;
            lat_addr <= '0;
        end else if (accept) begin
            lat_q    <= live;
            lat_addr <= bus.req_addr;
        end
    end

    // Storage: cleared by reset, byte-lane writes when a store commits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (exec && acc.write) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) begin
                    mem[widx][8*k +: 8] <= wsh[8*k +: 8];
                end
            end
        end
    end

    // Registered handshake and response outputs; response data held through RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            bus.req_ready <= (state_next == S_IDLE);
            bus.rsp_valid <= (state_next == S_RESP);
            if (exec) begin
                bus.rsp_rdata <= rfmt;
                bus.rsp_err   <= ferr;
            end
        end
    end
endmodule
